// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU types: word_t, RAM handshake state, arbiter states.
// Revision : 1.0
// ============================================================================
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IGNT = 2'b01,
    DGNT = 2'b10
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } port_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Cache-side and RAM-side bundle of the icache/dcache RAM arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port RAM arbiter for icache/dcache, grant held until ACCESS.
//            ARB_RR_EN selects round-robin; otherwise dcache has fixed priority.
// Revision : 1.0
// ============================================================================
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              w_dreq;
  logic              w_pick_d;
  logic              w_iwait;
  logic              w_dwait;
  logic              w_ren;
  logic              w_wen;
  logic [ADDR_W-1:0] w_ramaddr;
  logic [DATA_W-1:0] w_ramstore;

  assign w_dreq = bus.dREN | bus.dWEN;

`ifdef ARB_RR_EN
  port_t r_last_grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_grant <= GNT_I;
    end else if (!w_iwait) begin
      r_last_grant <= GNT_I;
    end else if (!w_dwait) begin
      r_last_grant <= GNT_D;
    end
  end
`endif

  // Decides only whether the dcache wins an arbitration made in IDLE.
  always_comb begin
    w_pick_d = w_dreq;
`ifdef ARB_RR_EN
    if (w_dreq && bus.iREN) begin
      w_pick_d = (r_last_grant == GNT_I);
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_iwait      = 1'b1;
    w_dwait      = 1'b1;
    w_ren        = 1'b0;
    w_wen        = 1'b0;
    w_ramaddr    = '0;
    w_ramstore   = '0;
    case (r_state)
      IDLE: begin
        if (w_dreq && w_pick_d) begin
          w_next_state = DGNT;
        end else if (bus.iREN) begin
          w_next_state = IGNT;
        end
      end
      IGNT: begin
        w_ren     = 1'b1;
        w_ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          w_next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          w_iwait      = 1'b0;
          w_next_state = IDLE;
        end
      end
      DGNT: begin
        w_ramaddr = bus.daddr;
        if (bus.dWEN) begin
          w_wen      = 1'b1;
          w_ramstore = bus.dstore;
        end else begin
          w_ren = 1'b1;
        end
        // A withdrawn request abandons the grant even if the RAM answers now.
        if (!w_dreq) begin
          w_next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          w_dwait      = 1'b0;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign bus.iwait    = w_iwait;
  assign bus.dwait    = w_dwait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramREN   = w_ren;
  assign bus.ramWEN   = w_wen;
  assign bus.ramaddr  = w_ramaddr;
  assign bus.ramstore = w_ramstore;

endmodule
`default_nettype wire
